// File: rtl/port_controller_if.sv
// Bus bundle between the requesters / port unit and the port controller.
// The controller is the slave: it answers requests and drives the port strobes.
interface port_controller_if #(
  parameter int unsigned WORD_SIZE = 16
);
  // Requester side
  logic [1:0]             req;
  logic [1:0]             req_write;
  logic [2*WORD_SIZE-1:0] req_addr;
  logic [2*WORD_SIZE-1:0] req_data;
  logic [1:0]             ack;
  logic [WORD_SIZE-1:0]   rsp_data;
  logic                   rsp_error;
  // Port unit side
  logic [WORD_SIZE-1:0]   portaddr;
  logic [WORD_SIZE-1:0]   portval;
  logic                   get_enable;
  logic                   set_enable;
  logic [WORD_SIZE-1:0]   portout;
  logic                   port_ready;
  // Status
  logic                   halted;

  modport slave (
    input  req, req_write, req_addr, req_data, portout, port_ready,
    output ack, rsp_data, rsp_error, portaddr, portval,
           get_enable, set_enable, halted
  );

  modport master (
    output req, req_write, req_addr, req_data, portout, port_ready,
    input  ack, rsp_data, rsp_error, portaddr, portval,
           get_enable, set_enable, halted
  );
endinterface

// File: rtl/port_controller.sv
// Round-robin sequencer between CPU (requester 0) and debug (requester 1)
// in front of the I/O port unit. Issues one-cycle get/set strobes, waits for
// port_ready with a bounded timeout, and latches a sticky halt on a
// successful write to port 0.
module port_controller #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned TIMEOUT   = 8
) (
  input logic              clk,
  input logic              rst_n,
  port_controller_if.slave bus
);

  localparam int unsigned   CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e               state_q;
  logic                 grant_q;
  logic                 write_q;
  logic                 last_grant_q;
  logic                 halted_q;
  logic [CW-1:0]        cnt_q;
  logic [1:0]           ack_q;
  logic [WORD_SIZE-1:0] rsp_data_q;
  logic                 rsp_error_q;
  logic [WORD_SIZE-1:0] portaddr_q;
  logic [WORD_SIZE-1:0] portval_q;
  logic                 get_q;
  logic                 set_q;

  logic [1:0]           elig_d;
  logic                 grant_d;
  logic                 write_d;
  logic [WORD_SIZE-1:0] addr_d;
  logic [WORD_SIZE-1:0] data_d;

  // Arbitration: CPU is ineligible while halted; on a tie the requester
  // that was not granted last time wins.
  always_comb begin
    elig_d  = {bus.req[1], bus.req[0] & ~halted_q};
    grant_d = (elig_d == 2'b11) ? ~last_grant_q : elig_d[1];
    write_d = bus.req_write[grant_d];
    addr_d  = grant_d ? bus.req_addr[2*WORD_SIZE-1:WORD_SIZE]
                      : bus.req_addr[WORD_SIZE-1:0];
    data_d  = grant_d ? bus.req_data[2*WORD_SIZE-1:WORD_SIZE]
                      : bus.req_data[WORD_SIZE-1:0];
  end

  // Transaction FSM with all outputs registered. Strobes are loaded on the
  // grant edge so they are high exactly while in ISSUE, and ack is loaded on
  // the WAIT exit edge so it is high exactly while in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      write_q      <= 1'b0;
      last_grant_q <= 1'b1;
      halted_q     <= 1'b0;
      cnt_q        <= '0;
      ack_q        <= '0;
      rsp_data_q   <= '0;
      rsp_error_q  <= 1'b0;
      portaddr_q   <= '0;
      portval_q    <= '0;
      get_q        <= 1'b0;
      set_q        <= 1'b0;
    end else begin
      ack_q <= '0;
      get_q <= 1'b0;
      set_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|elig_d) begin
            grant_q      <= grant_d;
            write_q      <= write_d;
            last_grant_q <= grant_d;
            portaddr_q   <= addr_d;
            portval_q    <= data_d;
            set_q        <= write_d;
            get_q        <= ~write_d;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (bus.port_ready) begin
            rsp_data_q     <= write_q ? '0 : bus.portout;
            rsp_error_q    <= 1'b0;
            ack_q[grant_q] <= 1'b1;
            state_q        <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            rsp_data_q     <= '0;
            rsp_error_q    <= 1'b1;
            ack_q[grant_q] <= 1'b1;
            state_q        <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (write_q && (portaddr_q == '0) && !rsp_error_q) begin
            halted_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack        = ack_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_error  = rsp_error_q;
  assign bus.portaddr   = portaddr_q;
  assign bus.portval    = portval_q;
  assign bus.get_enable = get_q;
  assign bus.set_enable = set_q;
  assign bus.halted     = halted_q;

endmodule

// File: tb/tb_port_controller.sv
// Directed bench for port_controller: a table of single transactions plus
// hand-written sequences for arbitration, halt lockout and mid-flight reset.
module tb_port_controller;
  localparam int unsigned W  = 16;
  localparam int unsigned TO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  port_controller_if #(.WORD_SIZE(W)) bus ();
  port_controller #(.WORD_SIZE(W), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic         who;
    logic         wr;
    logic [W-1:0] addr;
    logic [W-1:0] data;
    logic [W-1:0] pout;
    int unsigned  delay;    // port_ready low for this many WAIT cycles
    logic         toggle;   // scramble req_addr/req_data during WAIT
    int unsigned  exp_lat;  // cycle of ack, request sampled in cycle 0
    logic [W-1:0] exp_rsp;
    logic         exp_err;
    logic         exp_halt; // halted in the cycle after ack
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {10'b0, bus.ack, bus.rsp_data, bus.rsp_error, bus.portaddr,
            bus.portval, bus.get_enable, bus.set_enable, bus.halted};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one transaction; entered and left at a negedge of an IDLE cycle.
  task automatic txn(input vec_t v, input string tag);
    bit          strobe_ok = 1'b1;
    bit          hold_ok   = 1'b1;
    bit          got       = 1'b0;
    int unsigned lat       = 0;
    logic [1:0]  ackv      = '0;
    logic [W-1:0] rsp      = '0;
    logic        err       = 1'b0;
    bus.req[v.who]       = 1'b1;
    bus.req_write[v.who] = v.wr;
    if (v.who) begin
      bus.req_addr[2*W-1:W] = v.addr;
      bus.req_data[2*W-1:W] = v.data;
    end else begin
      bus.req_addr[W-1:0] = v.addr;
      bus.req_data[W-1:0] = v.data;
    end
    bus.portout    = v.pout;
    bus.port_ready = 1'b0;
    for (int unsigned c = 1; c <= 40; c++) begin
      step();
      if (bus.set_enable !== ((c == 1) && v.wr))  strobe_ok = 1'b0;
      if (bus.get_enable !== ((c == 1) && !v.wr)) strobe_ok = 1'b0;
      if (bus.portaddr !== v.addr || bus.portval !== v.data) hold_ok = 1'b0;
      if (bus.ack !== 2'b00) begin
        got  = 1'b1;
        lat  = c;
        ackv = bus.ack;
        rsp  = bus.rsp_data;
        err  = bus.rsp_error;
        break;
      end
      bus.port_ready = (c >= 2 + v.delay);
      if (v.toggle && c >= 2) begin
        if (v.who) begin
          bus.req_addr[2*W-1:W] = W'($urandom);
          bus.req_data[2*W-1:W] = W'($urandom);
        end else begin
          bus.req_addr[W-1:0] = W'($urandom);
          bus.req_data[W-1:0] = W'($urandom);
        end
      end
    end
    bus.req[v.who] = 1'b0;
    bus.port_ready = 1'b0;
    check({tag, "_acked"}, 64'(got), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
    check({tag, "_ack"}, 64'(ackv), v.who ? 64'd2 : 64'd1);
    check({tag, "_rsp_data"}, 64'(rsp), 64'(v.exp_rsp));
    check({tag, "_rsp_error"}, 64'(err), 64'(v.exp_err));
    check({tag, "_strobes"}, 64'(strobe_ok), 64'd1);
    check({tag, "_addr_hold"}, 64'(hold_ok), 64'd1);
    step();
    check({tag, "_halted"}, 64'(bus.halted), 64'(v.exp_halt));
  endtask

  // Starts a get, resets it in its second WAIT cycle, then checks quiet bus.
  task automatic reset_in_wait(input logic who, input string tag);
    bit quiet = 1'b1;
    bus.req_write[who] = 1'b0;
    if (who) bus.req_addr[2*W-1:W] = 16'h0066;
    else     bus.req_addr[W-1:0]   = 16'h0066;
    bus.port_ready = 1'b0;
    bus.portout    = 16'h5A5A;
    bus.req[who]   = 1'b1;
    repeat (3) step();
    check({tag, "_in_wait_addr"}, 64'(bus.portaddr), 64'h0066);
    rst_n        = 1'b0;
    bus.req[who] = 1'b0;
    step();
    check({tag, "_outs_after_reset"}, outs(), 64'd0);
    rst_n = 1'b1;
    repeat (5) begin
      step();
      if (bus.ack !== 2'b00 || bus.get_enable || bus.set_enable) quiet = 1'b0;
    end
    check({tag, "_quiet"}, 64'(quiet), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  nstb;
    int  nack;
    bit  lock_ok;
    vec_t v;

    //           who   wr    addr      data      pout      dly tgl  lat rsp       err   halt
    vecs[0] = '{1'b0, 1'b0, 16'h0005, 16'h0000, 16'h1234, 0,  1'b0, 3,  16'h1234, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 16'h0009, 16'h0000, 16'hBEEF, 8,  1'b0, 10, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 16'h0009, 16'h0000, 16'hCAFE, 7,  1'b0, 10, 16'hCAFE, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 16'h0003, 16'h55AA, 16'h7777, 2,  1'b0, 5,  16'h0000, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 16'h0000, 16'h0007, 16'h0000, 8,  1'b0, 10, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h8001, 1,  1'b0, 4,  16'h8001, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 16'h0021, 16'h3131, 16'h0F0F, 3,  1'b1, 6,  16'h0F0F, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 16'h0000, 16'h0007, 16'h0000, 0,  1'b0, 3,  16'h0000, 1'b0, 1'b1};

    bus.req        = '0;
    bus.req_write  = '0;
    bus.req_addr   = '0;
    bus.req_data   = '0;
    bus.portout    = '0;
    bus.port_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs(), 64'd0);
    rst_n = 1'b1;

    // Both requesters issue sets continuously from reset: CPU first, then alternate
    bus.req_write  = 2'b11;
    bus.req_addr   = {16'h0020, 16'h0010};
    bus.req_data   = {16'h2222, 16'h1111};
    bus.port_ready = 1'b1;
    bus.req        = 2'b11;
    nstb = 0;
    nack = 0;
    for (int c = 1; c <= 24; c++) begin
      step();
      if (bus.set_enable) begin
        check("rr_portval", 64'(bus.portval), (nstb % 2 == 0) ? 64'h1111 : 64'h2222);
        check("rr_portaddr", 64'(bus.portaddr), (nstb % 2 == 0) ? 64'h0010 : 64'h0020);
        nstb++;
      end
      if (bus.ack !== 2'b00) begin
        check("rr_ack", 64'(bus.ack), (nack % 2 == 0) ? 64'd1 : 64'd2);
        check("rr_ack_cycle", 64'(c), 64'(3 + 4 * nack));
        nack++;
        if (nack == 4) begin
          bus.req = '0;
          break;
        end
      end
    end
    check("rr_ack_count", 64'(nack), 64'd4);
    bus.port_ready = 1'b0;
    step();

    // Single-transaction table; last row halts the machine
    for (int i = 0; i < 8; i++) begin
      txn(vecs[i], $sformatf("vec%0d", i));
    end

    // CPU locked out while halted
    bus.req_write[0]    = 1'b1;
    bus.req_addr[W-1:0] = 16'h0044;
    bus.req_data[W-1:0] = 16'h0099;
    bus.req[0]          = 1'b1;
    lock_ok = 1'b1;
    repeat (20) begin
      step();
      if (bus.ack !== 2'b00 || bus.get_enable || bus.set_enable ||
          bus.portaddr !== 16'h0000 || bus.portval !== 16'h0007) lock_ok = 1'b0;
    end
    check("halt_lockout", 64'(lock_ok), 64'd1);

    // Debug still served while halted and CPU still requesting
    v = '{1'b1, 1'b0, 16'h0030, 16'h0000, 16'h4321, 0, 1'b0, 3, 16'h4321, 1'b0, 1'b1};
    txn(v, "dbg_while_halted");
    bus.req = '0;

    // Reset during WAIT clears halt and aborts without ack
    reset_in_wait(1'b1, "rst_dbg");
    reset_in_wait(1'b0, "rst_cpu");

    // CPU served normally after reset
    v = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'hA5A5, 0, 1'b0, 3, 16'hA5A5, 1'b0, 1'b0};
    txn(v, "cpu_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
